// File: rtl/tick_scheduler.sv
// Programmable-period tick generator with a round-robin grant issued on every tick.
// Period updates are deferred to a period boundary so the tick spacing never glitches.
module tick_scheduler #(
   parameter int NSize = 3,
   parameter int NReq  = 4,
   parameter int NId   = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [NSize-1:0] cfg_period,
   output logic             cfg_ready,
   input  logic [NReq-1:0]  req,
   output logic             tick,
   output logic [NReq-1:0]  grant,
   output logic [NId-1:0]   grant_id,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [NSize-1:0] count_q, count_d;
   logic [NSize-1:0] period_q, period_d;
   logic [NSize-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic [NId-1:0]   rr_q, rr_d;
   logic             tick_q, tick_d;
   logic [NReq-1:0]  grant_q, grant_d;
   logic [NId-1:0]   grant_id_q, grant_id_d;

   logic             boundary;
   logic             accept;
   logic             direct;
   logic             found;
   logic [NId-1:0]   idx;

   // cfg handshake: a period is transferred on any cycle where cfg_valid and cfg_ready are both 1;
   // cfg_ready stays low while a deferred period waits for the next boundary.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      period_d    = period_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      cfg_ready_d = cfg_ready_q;
      rr_d        = rr_q;
      tick_d      = 1'b0;
      grant_d     = '0;
      grant_id_d  = '0;
      found       = 1'b0;
      idx         = '0;

      boundary = (state_q != IDLE) && (count_q == period_q);
      accept   = cfg_valid && cfg_ready_q;

      case (state_q)
         IDLE: begin
            count_d = '0;
            if (enable) state_d = RUN;
         end
         RUN: begin
            count_d = boundary ? '0 : count_q + 1'b1;
            if (!enable) state_d = DRAIN;
         end
         DRAIN: begin
            count_d = boundary ? '0 : count_q + 1'b1;
            if (enable)        state_d = RUN;
            else if (boundary) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Nothing is in flight in IDLE (or when entering it), so a new period can land directly.
      direct = (state_q == IDLE) || (state_d == IDLE);

      if (boundary && pend_vld_q) begin
         period_d    = pend_q;
         pend_vld_d  = 1'b0;
         cfg_ready_d = 1'b1;
      end
      if (accept) begin
         if (direct) begin
            period_d = cfg_period;
         end else begin
            pend_d      = cfg_period;
            pend_vld_d  = 1'b1;
            cfg_ready_d = 1'b0;
         end
      end

      if (boundary) begin
         tick_d = 1'b1;
         for (int i = 0; i < NReq; i++) begin
            idx = NId'((int'(rr_q) + i) % NReq);
            if (!found && req[idx]) begin
               found          = 1'b1;
               grant_d[idx]   = 1'b1;
               grant_id_d     = idx;
               rr_d           = NId'((int'(idx) + 1) % NReq);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         period_q    <= '1;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         cfg_ready_q <= 1'b1;
         rr_q        <= '0;
         tick_q      <= 1'b0;
         grant_q     <= '0;
         grant_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         period_q    <= period_d;
         pend_q      <= pend_d;
         pend_vld_q  <= pend_vld_d;
         cfg_ready_q <= cfg_ready_d;
         rr_q        <= rr_d;
         tick_q      <= tick_d;
         grant_q     <= grant_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign tick      = tick_q;
   assign grant     = grant_q;
   assign grant_id  = grant_id_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: table of period/request vectors, hand sequences for the
// reconfiguration, drain and reset corners, and random traffic against a queue-based model.
module tb_tick_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       cfg_valid;
   logic [2:0] cfg_period;
   logic       cfg_ready;
   logic [3:0] req;
   logic       tick;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic [1:0] dbg_state;

   tick_scheduler #(.NSize(3), .NReq(4), .NId(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_period(cfg_period),
      .cfg_ready (cfg_ready),
      .req       (req),
      .tick      (tick),
      .grant     (grant),
      .grant_id  (grant_id),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: position within the current period, pending periods in a queue.
   bit         m_on, m_stop, m_acc, m_end, m_got;
   int         m_pos, m_per, m_rr;
   int         m_pend[$];
   logic       e_tick, e_ready, e_busy;
   logic [3:0] e_grant;
   logic [1:0] e_gid;

   always @(posedge clock) begin
      if (reset) begin
         m_on = 0; m_stop = 0; m_pos = 0; m_per = 7; m_rr = 0;
         m_pend.delete();
         e_tick = 0; e_grant = 0; e_gid = 0; e_ready = 1; e_busy = 0;
      end else begin
         m_acc  = cfg_valid && e_ready;
         e_tick = 0; e_grant = 0; e_gid = 0;
         if (!m_on) begin
            if (m_acc) m_per = int'(cfg_period);
            if (enable) begin m_on = 1; m_stop = 0; m_pos = 0; end
         end else begin
            m_end = (m_pos == m_per);
            if (m_end) begin
               e_tick = 1;
               m_got  = 0;
               for (int k = 0; k < 4; k++) begin
                  if (!m_got && req[(m_rr + k) % 4]) begin
                     m_got = 1;
                     e_grant = 4'(1 << ((m_rr + k) % 4));
                     e_gid   = 2'((m_rr + k) % 4);
                  end
               end
               if (m_got) m_rr = (int'(e_gid) + 1) % 4;
               m_pos = 0;
               if (m_pend.size() > 0) begin m_per = m_pend.pop_front(); e_ready = 1; end
               if (enable)      m_stop = 0;
               else if (m_stop) m_on = 0;
               else             m_stop = 1;
            end else begin
               m_pos++;
               m_stop = !enable;
            end
            if (m_acc) begin
               if (!m_on) m_per = int'(cfg_period);
               else begin m_pend.push_back(int'(cfg_period)); e_ready = 0; end
            end
         end
         e_busy = m_on;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("model_tick", tick, e_tick);
         check("model_grant", grant, e_grant);
         check("model_grant_id", grant_id, e_gid);
         check("model_cfg_ready", cfg_ready, e_ready);
         check("model_busy", busy, e_busy);
      end
   end

   task automatic step(input int k);
      repeat (k) begin @(posedge clock); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(posedge clock); #1; n++;
      end while (tick !== 1'b1 && n < 64);
      if (tick !== 1'b1) begin
         checks++; failures++;
         $display("FAIL wait_tick actual=no_tick required=tick_within_64");
      end
   endtask

   typedef struct {
      logic [2:0] per;
      logic [3:0] rq;
      int         lat;
      int         spacing;
      logic [3:0] g0;
      logic [3:0] g1;
      logic [1:0] id1;
   } vec_t;

   vec_t       vecs[6];
   logic [3:0] g_seq[5];
   int         n, nticks;

   initial begin
      vecs[0] = '{3'd7, 4'b0001, 9, 8, 4'b0001, 4'b0001, 2'd0};
      vecs[1] = '{3'd2, 4'b1111, 4, 3, 4'b0001, 4'b0010, 2'd1};
      vecs[2] = '{3'd0, 4'b0101, 2, 1, 4'b0001, 4'b0100, 2'd2};
      vecs[3] = '{3'd3, 4'b1000, 5, 4, 4'b1000, 4'b1000, 2'd3};
      vecs[4] = '{3'd5, 4'b0000, 7, 6, 4'b0000, 4'b0000, 2'd0};
      vecs[5] = '{3'd1, 4'b0110, 3, 2, 4'b0010, 4'b0100, 2'd2};
      g_seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      enable = 0; cfg_valid = 0; cfg_period = 0; req = 0;
      @(negedge clock);
      do_reset();
      chk_en = 1'b1;
      check("rst_tick", tick, 1'b0);
      check("rst_grant", grant, 4'b0000);
      check("rst_grant_id", grant_id, 2'd0);
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg_state, 2'd0);

      // Table: period/request pattern -> first-tick latency, spacing, first two grants.
      for (int i = 0; i < 6; i++) begin
         enable = 0; req = vecs[i].rq;
         do_reset();
         cfg_valid = 1; cfg_period = vecs[i].per;
         step(1);
         cfg_valid = 0;
         check("vec_cfg_ready", cfg_ready, 1'b1);
         enable = 1;
         wait_tick(n);
         check("vec_latency", n, vecs[i].lat);
         check("vec_grant0", grant, vecs[i].g0);
         check("vec_busy", busy, 1'b1);
         wait_tick(n);
         check("vec_spacing", n, vecs[i].spacing);
         check("vec_grant1", grant, vecs[i].g1);
         check("vec_grant_id1", grant_id, vecs[i].id1);
      end

      // Round-robin rotation over all requesters, then a tick with no requests.
      enable = 0; req = 4'b1111;
      do_reset();
      cfg_valid = 1; cfg_period = 3'd1;
      step(1);
      cfg_valid = 0; enable = 1;
      for (int k = 0; k < 5; k++) begin
         wait_tick(n);
         check("rr_grant", grant, g_seq[k]);
      end
      req = 4'b0000;
      wait_tick(n);
      check("noreq_tick", tick, 1'b1);
      check("noreq_grant", grant, 4'b0000);

      // Period change while running: old period completes, new spacing follows.
      enable = 0; req = 4'b0001;
      do_reset();
      enable = 1;
      wait_tick(n);
      step(3);
      cfg_valid = 1; cfg_period = 3'd2;
      step(1);
      cfg_valid = 0;
      check("cfg_ready_low", cfg_ready, 1'b0);
      wait_tick(n);
      check("cfg_old_period_end", n, 4);
      check("cfg_ready_back", cfg_ready, 1'b1);
      wait_tick(n);
      check("cfg_new_spacing_a", n, 3);
      wait_tick(n);
      check("cfg_new_spacing_b", n, 3);

      // Drain: disable at count 2, one final tick, then idle and silent.
      enable = 0;
      do_reset();
      enable = 1;
      wait_tick(n);
      step(2);
      enable = 0;
      step(1);
      check("drain_state", dbg_state, 2'd2);
      check("drain_busy", busy, 1'b1);
      wait_tick(n);
      check("drain_final_tick", n, 5);
      check("drain_idle_busy", busy, 1'b0);
      check("drain_idle_state", dbg_state, 2'd0);
      nticks = 0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (tick === 1'b1) nticks++;
      end
      check("idle_no_ticks", nticks, 0);

      // Re-enable during drain at count 5: spacing unchanged, back to RUN.
      enable = 1;
      wait_tick(n);
      step(2);
      enable = 0;
      step(3);
      enable = 1;
      wait_tick(n);
      check("reen_tick", n, 3);
      check("reen_state", dbg_state, 2'd1);
      wait_tick(n);
      check("reen_spacing", n, 8);

      // Reset with a deferred period outstanding discards it.
      enable = 0;
      do_reset();
      enable = 1;
      wait_tick(n);
      step(1);
      cfg_valid = 1; cfg_period = 3'd2;
      step(1);
      cfg_valid = 0;
      check("pend_cfg_ready", cfg_ready, 1'b0);
      step(3);
      reset = 1;
      step(1);
      check("mid_rst_tick", tick, 1'b0);
      check("mid_rst_grant", grant, 4'b0000);
      check("mid_rst_cfg_ready", cfg_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      reset = 0;
      wait_tick(n);
      check("mid_rst_period7", n, 9);

      // Random traffic; the model compares every cycle.
      enable = 1;
      for (int k = 0; k < 4000; k++) begin
         reset      = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 24) == 0) enable = ~enable;
         cfg_valid  = ($urandom_range(0, 7) == 0);
         cfg_period = 3'($urandom_range(0, 7));
         req        = 4'($urandom_range(0, 15));
         step(1);
      end
      reset = 0; cfg_valid = 0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
